mmix_mem_responder: RTL
=======================

// Module: mmix_mem_responder
// PURPOSE
//  Memory-side responder for the load/store unit's 64-bit request interface
//  (mem_address/mem_datasize/mem_read/mem_write/mem_writedata -> mem_readdata/mem_done).
//  Latches one request, aligns it per MMIX rules and runs it as 1-4 big-endian
//  16-bit beats on an Avalon-MM master port (DE0 SDRAM/SRAM bridge). Pulses mem_done
//  once per request, with a right-justified, zero-extended result; sign extension stays upstream.
// PARAMETERS
//  ADDR_W  22  width of avm_address (halfword address); higher mem_address bits ignored
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      asynchronous, active-high reset
//  mem_address    in   64     byte address from initiator (unaligned allowed)
//  mem_datasize   in   2      0 byte, 1 wyde, 2 tetra, 3 octa
//  mem_read       in   1      read request level, held until mem_done
//  mem_write      in   1      write request level, held until mem_done
//  mem_writedata  in   64     store data, right-justified
//  mem_readdata   out  64     load result, right-justified, zero-extended
//  mem_done       out  1      one-cycle completion pulse (registered)
//  avm_address    out  ADDR_W halfword address
//  avm_byteenable out  2      [1]=bits15:8 (even byte), [0]=bits7:0 (odd byte)
//  avm_read       out  1      read command
//  avm_write      out  1      write command
//  avm_writedata  out  16     write beat data
//  avm_readdata   in   16     read beat data, valid with avm_readdatavalid
//  avm_readdatavalid in 1     read data return, >=1 cycle after read acceptance
//  avm_waitrequest in  1      command stalled while high
// BEHAVIOUR
//  - Reset: state IDLE; mem_done=0, mem_readdata=0, avm_read=avm_write=0,
//    avm_address=0, avm_byteenable=0, avm_writedata=0.
//  - States: IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE.
//  - IDLE: mem_read -> latch request, goto RD_CMD; else mem_write -> latch, goto WR_CMD.
//    Both high: read wins. Request inputs are ignored outside IDLE.
//  - Latch: size s, aligned A = mem_address & ~((1<<s)-1), wdata, beat=0,
//    nbeats = (s<=1) ? 1 : (1<<s)/2 (wyde 1, tetra 2, octa 4).
//  - avm_address = A[ADDR_W:1] + beat (wraps modulo 2^ADDR_W). Beat 0 holds the most significant bytes.
//  - byteenable: byte -> A[0]?2'b01:2'b10; all others 2'b11.
//  - Write beat data: byte -> {wdata[7:0],wdata[7:0]}; wyde -> wdata[15:0];
//    tetra/octa beat k -> wdata[16*(nbeats-1-k) +: 16].
//  - RD_CMD: avm_read=1 until cycle with waitrequest=0, then RD_WAIT (avm_read=0).
//    RD_WAIT: on readdatavalid shift the beat in (acc = {acc[47:0],rd}; byte picks
//    rd[15:8] if A[0]=0 else rd[7:0]). Not last beat -> beat++, RD_CMD; last -> DONE.
//  - WR_CMD: avm_write=1 until waitrequest=0; not last -> beat++, stay; last -> DONE.
//  - One outstanding read. readdatavalid outside RD_WAIT is discarded.
//  - DONE: mem_done=1 for exactly 1 cycle, then IDLE. mem_readdata is updated on
//    entry to DONE (reads only) and holds until the next read completes. Writes leave it unchanged.
//  - Latency with no waits and readdatavalid 1 cycle after acceptance (T = sample):
//    byte/wyde write done @T+2, octa write @T+5; byte read @T+3, octa read @T+9.
//  - The cycle after DONE is IDLE and may accept a new request back-to-back.
//  - Overflow/range checks are not done here (V_BIT is upstream); no errors reported.
//  - Reset mid-transaction: immediate return to IDLE, all avm_* commands drop,
//    no mem_done; late readdatavalid is ignored.
// TESTING
//  - LDB: addr 0x1003, size0, mem rd 0xA5B6 @halfword 0x801 -> addr 0x801, be 01,
//    mem_readdata=0xB6, mem_done once @T+3.
//  - STO: addr 0x2007 (aligns to 0x2000), wdata 0x0123456789ABCDEF -> 4 writes
//    @0x1000..0x1003 data 0123,4567,89AB,CDEF, be 11; done @T+5.
//  - STB: addr 0x10, wdata 0xFF -> be 10, writedata 0xFFFF. Same with addr 0x11 -> be 01.
//  - LDT: addr 0x4, waitrequest high 3 cycles each beat and readdatavalid 2 cycles later
//    -> avm_read held stable, result {beat0,beat1} zero-extended, single done pulse.
//  - Back-to-back: new read present the cycle after mem_done -> accepted, no
//    duplicate beats; mem_read & mem_write both high -> read performed only.
//  - Reset asserted in RD_WAIT of an octa read, then readdatavalid -> no done,
//    outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/mmix_mem_responder_if.sv
// mmix_mem_responder_if: load/store request bus plus the Avalon-MM 16-bit beat port of the responder
interface mmix_mem_responder_if #(
  parameter int ADDR_W = 22
);
  logic [63:0] mem_address;
  logic [1:0] mem_datasize;
  logic mem_read;
  logic mem_write;
  logic [63:0] mem_writedata;
  logic [63:0] mem_readdata;
  logic mem_done;
  logic [ADDR_W-1:0] avm_address;
  logic [1:0] avm_byteenable;
  logic avm_read;
  logic avm_write;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic avm_readdatavalid;
  logic avm_waitrequest;
  modport master (
    output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input mem_readdata, mem_done,
    input avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );
  modport slave (
    input mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    input avm_readdata, avm_readdatavalid, avm_waitrequest,
    output mem_readdata, mem_done,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
  );
endinterface

// File: rtl/mmix_mem_responder.sv
// mmix_mem_responder: runs one aligned MMIX load/store as 1-4 big-endian 16-bit Avalon-MM beats
module mmix_mem_responder #(
  parameter int ADDR_W = 22
) (
  input logic clk,
  input logic reset,
  mmix_mem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE} state_t;
  state_t state;
  logic [1:0] size, beat;
  logic a0, is_last;
  logic [ADDR_W-1:0] base, req_base;
  logic [63:0] wdata, acc_nxt;
  logic [47:0] acc;
  // index of the final beat: byte/wyde 0, tetra 1, octa 3
  function automatic logic [1:0] last_of(input logic [1:0] s);
    return {s == 2'd3, s[1]};
  endfunction
  function automatic logic [15:0] beat_data(input logic [1:0] s, input logic [63:0] d, input logic [1:0] k);
    return s == 2'd0 ? {d[7:0], d[7:0]} : 16'(d >> {last_of(s) - k, 4'b0});
  endfunction
  assign req_base = bus.mem_address[ADDR_W:1] & ~ADDR_W'(last_of(bus.mem_datasize));
  assign is_last = beat == last_of(size);
  assign acc_nxt = size == 2'd0 ? {56'd0, a0 ? bus.avm_readdata[7:0] : bus.avm_readdata[15:8]}
                                : {acc, bus.avm_readdata};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      size <= '0;
      beat <= '0;
      a0 <= 1'b0;
      base <= '0;
      wdata <= '0;
      acc <= '0;
      bus.mem_done <= 1'b0;
      bus.mem_readdata <= '0;
      bus.avm_read <= 1'b0;
      bus.avm_write <= 1'b0;
      bus.avm_address <= '0;
      bus.avm_byteenable <= '0;
      bus.avm_writedata <= '0;
    end else
      case (state)
        IDLE: if (bus.mem_read || bus.mem_write) begin
          size <= bus.mem_datasize;
          a0 <= bus.mem_address[0];
          base <= req_base;
          wdata <= bus.mem_writedata;
          beat <= '0;
          acc <= '0;
          bus.avm_address <= req_base;
          bus.avm_byteenable <= bus.mem_datasize != 2'd0 ? 2'b11 : bus.mem_address[0] ? 2'b01 : 2'b10;
          bus.avm_read <= bus.mem_read;
          bus.avm_write <= !bus.mem_read;
          bus.avm_writedata <= beat_data(bus.mem_datasize, bus.mem_writedata, 2'd0);
          state <= bus.mem_read ? RD_CMD : WR_CMD;
        end
        RD_CMD: if (!bus.avm_waitrequest) begin
          bus.avm_read <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: if (bus.avm_readdatavalid) begin
          acc <= acc_nxt[47:0];
          if (is_last) begin
            bus.mem_readdata <= acc_nxt;
            bus.mem_done <= 1'b1;
            state <= DONE;
          end else begin
            beat <= beat + 2'd1;
            bus.avm_address <= base + ADDR_W'(beat + 2'd1);
            bus.avm_read <= 1'b1;
            state <= RD_CMD;
          end
        end
        WR_CMD: if (!bus.avm_waitrequest) begin
          if (is_last) begin
            bus.avm_write <= 1'b0;
            bus.mem_done <= 1'b1;
            state <= DONE;
          end else begin
            beat <= beat + 2'd1;
            bus.avm_address <= base + ADDR_W'(beat + 2'd1);
            bus.avm_writedata <= beat_data(size, wdata, beat + 2'd1);
          end
        end
        DONE: begin
          bus.mem_done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
